output_port_tx: RTL
===================

# output_port_tx

Transmit-side leaf interface port. It accepts payload words from user logic over a valid/ack handshake and buffers them in a small FIFO. Each word is wrapped into a BFT packet addressed to a remote input port's buffer slot, and the packet is held on the leaf bus until the arbiter acks it. Credit-based flow control keeps the remote receive buffer (2^NUM_ADDR_BITS slots) from overflowing. Freespace-update packets returned by the remote input port replenish the credits.

## Interface
Parameters:
- PACKET_BITS, 97, total packet width
- NUM_LEAF_BITS, 6, leaf address field width
- NUM_PORT_BITS, 4, port field width
- NUM_ADDR_BITS, 7, remote buffer slot address width; remote depth = 2^NUM_ADDR_BITS
- PAYLOAD_BITS, 64, payload width
- PORT_No, 2, local port number; incoming packets with this port field are credit updates for this block
- FREESPACE_UPDATE_SIZE, 64, credits returned per update packet
- FIFO_ASIZE, 4, user FIFO depth = 2^FIFO_ASIZE

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- dst_leaf  in  NUM_LEAF_BITS  destination leaf; quasi-static
- dst_port  in  NUM_PORT_BITS  destination port; quasi-static
- dout_leaf_interface2bft  out  PACKET_BITS  outgoing packet; MSB = valid
- ack_bft2interface  in  1  arbiter accepted the current packet
- din_leaf_bft2interface  in  PACKET_BITS  incoming packet stream, watched for credit updates
- din_user  in  PAYLOAD_BITS  user payload
- vld_user2interface  in  1  user payload valid
- ack_interface2user  out  1  equals ~fifo_full; a word transfers when vld & ack

## Operation
- Packet format: {1'b1, dst_leaf, dst_port, zeros, slot_addr[NUM_ADDR_BITS-1:0], payload}. slot_addr occupies [PAYLOAD_BITS+NUM_ADDR_BITS-1:PAYLOAD_BITS]. The zero field fills the remaining bits.
- Credit counter: NUM_ADDR_BITS+1 bits, reset to 2^NUM_ADDR_BITS.
  - Decrements by 1 on each FIFO pop.
  - Increments by FREESPACE_UPDATE_SIZE when an update packet arrives.
  - An update packet is din valid bit = 1 AND its port field [PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS] == PORT_No.
  - Pop and update in the same cycle apply the net change (+FREESPACE_UPDATE_SIZE-1).
  - The counter saturates at 2^NUM_ADDR_BITS and never goes below 0.
- Slot address counter: NUM_ADDR_BITS bits, reset 0. Increments on each LOAD and wraps from 2^NUM_ADDR_BITS-1 to 0.
- FSM:
  - IDLE: if !empty and credit != 0, assert rinc and go to LOAD.
  - LOAD: capture FIFO rdata into the packet register with valid = 1, then go to SEND.
  - SEND: hold the packet until ack_bft2interface. On ack, clear valid.
    - If !empty and credit after this cycle != 0, assert rinc and go to LOAD.
    - Otherwise go to IDLE.
- ack_bft2interface is ignored outside SEND.
- The FIFO is a full/empty-guarded synchronous FIFO.
  - A write while full is impossible, because ack is low when full.
  - A simultaneous read and write while full is still refused on the write side.

## Timing
- Reset values:
  - dout_leaf_interface2bft = 0
  - ack_interface2user = 1 once the FIFO is empty after reset
  - credit = 2^NUM_ADDR_BITS
  - slot address = 0
  - FSM = IDLE
  - FIFO flushed
- Latency: user word accepted at cycle t gives packet valid on the bus at t+3 at the earliest (t+1 IDLE/rinc, t+2 LOAD, t+3 SEND).
- Throughput: one packet per 2 cycles with immediate acks.
- The packet stays stable, valid held, until acked.
- Reset mid-SEND drops the packet and valid falls at the next edge. All credits are restored.
- A credit update arriving while credit = 0 lets IDLE issue rinc in the following cycle.

## Configuration
- OUTPUT_PORT_TX_PKT_COUNT_EN defined:
  - Adds output pkt_count [31:0], a count of packets acked by the arbiter.
  - Reset 0; wraps at 2^32.
- Not defined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package holds:
  - the packet field offset constants (valid bit, leaf, port and slot address positions)
  - the FSM state typedef (IDLE, LOAD, SEND)
- Natural sub-module: the team's existing SynFIFO (DSIZE=PAYLOAD_BITS, ASIZE=FIFO_ASIZE, RAM_TYPE "distributed"), instantiated for the user buffer.
- Credit and slot counters stay in the top module.

## Test plan
- Single word 0xDEADBEEF with dst_leaf=5, dst_port=3, ack held high:
  - bus packet has valid=1, leaf=5, port=3, slot=0, payload=0xDEADBEEF
  - second word gets slot=1
- Send 128 words with no updates:
  - exactly 128 packets, slots 0..127
  - the 129th word is held in the FIFO and no packet is emitted
  - one update packet (port=PORT_No) releases it within 3 cycles, with slot=0 (wrap)
- Arbiter ack withheld 10 cycles:
  - packet held bit-stable for 10 cycles
  - FIFO fills to 16 words, then ack_interface2user = 0
- Update packet and pop in the same cycle at credit=10: credit becomes 73 next cycle.
- Update packet with port != PORT_No, or with valid=0: credit unchanged.
- Reset asserted while in SEND:
  - valid = 0 next cycle
  - credit = 128, slot = 0
  - FIFO empty
  - pkt_count = 0 when OUTPUT_PORT_TX_PKT_COUNT_EN is defined

Source files
------------

// File: rtl/output_port_tx_pkg.sv
// Shared definitions for the output_port_tx leaf transmit port:
// packet field positions and the send FSM state type.
package output_port_tx_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} tx_state_t;

    // Field positions are derived from the block parameters so every user agrees on them.
    function automatic int pkt_valid_pos(int packet_bits);
        return packet_bits - 1;
    endfunction

    function automatic int pkt_leaf_msb(int packet_bits);
        return packet_bits - 2;
    endfunction

    function automatic int pkt_port_msb(int packet_bits, int leaf_bits);
        return packet_bits - 2 - leaf_bits;
    endfunction

    function automatic int pkt_slot_lsb(int payload_bits);
        return payload_bits;
    endfunction

endpackage

// File: rtl/output_port_tx_fifo.sv
// SynFIFO: full/empty-guarded synchronous FIFO with a registered read port.
// rdata is valid the cycle after a pop.
module SynFIFO #(
    parameter int DSIZE    = 64,
    parameter int ASIZE    = 4,
    parameter     RAM_TYPE = "distributed"
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rinc,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic [DSIZE-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam bit IS_DIST = (RAM_TYPE == "distributed");

    logic [DSIZE-1:0] mem [2**ASIZE];
    logic [ASIZE:0]   wptr, rptr;
    logic             do_w, do_r;

    assign empty = (wptr == rptr);
    assign full  = (wptr[ASIZE] != rptr[ASIZE]) && (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
    assign do_w  = winc && !full;
    assign do_r  = rinc && !empty;

    always_ff @(posedge clk) begin
        if (do_w)
            mem[wptr[ASIZE-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_w) wptr <= wptr + 1'b1;
            if (do_r) rptr <= rptr + 1'b1;
        end
    end

    // Block RAM output registers are left unreset; LUT RAM output is cleared.
    always_ff @(posedge clk) begin
        if (reset && IS_DIST)
            rdata <= '0;
        else if (do_r)
            rdata <= mem[rptr[ASIZE-1:0]];
    end

endmodule

// File: rtl/output_port_tx.sv
// Leaf transmit port: buffers user words, wraps them into BFT packets and
// paces them with remote-buffer credits. Option: OUTPUT_PORT_TX_PKT_COUNT_EN adds pkt_count.
module output_port_tx
    import output_port_tx_pkg::*;
#(
    parameter int PACKET_BITS           = 97,
    parameter int NUM_LEAF_BITS         = 6,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PAYLOAD_BITS          = 64,
    parameter int PORT_No               = 2,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int FIFO_ASIZE            = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
    input  logic [NUM_PORT_BITS-1:0] dst_port,
    output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
    input  logic                     ack_bft2interface,
    input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
    input  logic [PAYLOAD_BITS-1:0]  din_user,
    input  logic                     vld_user2interface,
    output logic                     ack_interface2user
`ifdef OUTPUT_PORT_TX_PKT_COUNT_EN
    ,
    output logic [31:0]              pkt_count
`endif
);
    localparam int VALID_POS = pkt_valid_pos(PACKET_BITS);
    localparam int PORT_MSB  = pkt_port_msb(PACKET_BITS, NUM_LEAF_BITS);
    localparam int ZERO_BITS = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS
                               - NUM_ADDR_BITS - PAYLOAD_BITS;
    localparam logic [NUM_ADDR_BITS+1:0] CREDIT_MAX = {2'b01, {NUM_ADDR_BITS{1'b0}}};
    localparam logic [NUM_ADDR_BITS+1:0] UPD_INC    = FREESPACE_UPDATE_SIZE[NUM_ADDR_BITS+1:0];

    tx_state_t                 state, state_next;
    logic                      rinc, fifo_empty, fifo_full, upd;
    logic [PAYLOAD_BITS-1:0]   fifo_rdata;
    logic [NUM_ADDR_BITS:0]    credit;
    logic [NUM_ADDR_BITS+1:0]  credit_add, credit_net;
    logic [NUM_ADDR_BITS-1:0]  slot;

    SynFIFO #(
        .DSIZE   (PAYLOAD_BITS),
        .ASIZE   (FIFO_ASIZE),
        .RAM_TYPE("distributed")
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .rinc (rinc),
        .winc (vld_user2interface),
        .wdata(din_user),
        .rdata(fifo_rdata),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assign ack_interface2user = !fifo_full;

    assign upd = din_leaf_bft2interface[VALID_POS] &&
                 (din_leaf_bft2interface[PORT_MSB -: NUM_PORT_BITS] == PORT_No[NUM_PORT_BITS-1:0]);

    // credit_add is the credit after this cycle ignoring a pop; it gates the SEND->LOAD decision.
    assign credit_add = {1'b0, credit} + (upd ? UPD_INC : '0);
    assign credit_net = credit_add - {{(NUM_ADDR_BITS+1){1'b0}}, rinc};

    always_comb begin
        state_next = state;
        rinc       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && credit != '0) begin
                    rinc       = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: state_next = SEND;
            SEND: begin
                if (ack_bft2interface) begin
                    if (!fifo_empty && credit_add != '0) begin
                        rinc       = 1'b1;
                        state_next = LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= IDLE;
            credit                  <= CREDIT_MAX[NUM_ADDR_BITS:0];
            slot                    <= '0;
            dout_leaf_interface2bft <= '0;
        end else begin
            state  <= state_next;
            credit <= (credit_net > CREDIT_MAX) ? CREDIT_MAX[NUM_ADDR_BITS:0]
                                                : credit_net[NUM_ADDR_BITS:0];
            if (state == LOAD) begin
                dout_leaf_interface2bft <= {1'b1, dst_leaf, dst_port, {ZERO_BITS{1'b0}},
                                            slot, fifo_rdata};
                slot                    <= slot + 1'b1;
            end else if (state == SEND && ack_bft2interface) begin
                dout_leaf_interface2bft[VALID_POS] <= 1'b0;
            end
        end
    end

`ifdef OUTPUT_PORT_TX_PKT_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            pkt_count <= '0;
        else if (state == SEND && ack_bft2interface)
            pkt_count <= pkt_count + 32'd1;
    end
`endif

endmodule
